// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: merges stage stall requests into per-register hold/bubble controls and sequences exception flushes.
// Controls are combinational from inputs and state; a busy MEM stage defers an exception flush until it releases.
module pipeline_ctrl #(
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_stallreq_i,
    input  logic             id_stallreq_i,
    input  logic             ex_stallreq_i,
    input  logic             mem_stallreq_i,
    input  logic             excp_i,
    input  logic [PC_W-1:0]  excp_vec_i,
    output logic [4:0]       stall_o,
    output logic [4:0]       bubble_o,
    output logic             flush_o,
    output logic [PC_W-1:0]  new_pc_o,
    output logic             excp_pending_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             timeout_o
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t           state_q;
    logic [PC_W-1:0]  vec_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_nxt;
    logic             timeout_q;
    logic             stall_any;

    // The deepest requesting stage wins; its pattern already covers shallower requests.
    always_comb begin
        stall_o  = '0;
        bubble_o = '0;
        flush_o  = 1'b0;
        new_pc_o = '0;
        if (!rst_i) begin
            if (state_q == PEND) begin
                if (mem_stallreq_i) begin
                    stall_o  = 5'b01111;
                    bubble_o = 5'b10000;
                end else begin
                    flush_o  = 1'b1;
                    new_pc_o = vec_q;
                end
            end else if (excp_i && !mem_stallreq_i) begin
                flush_o  = 1'b1;
                new_pc_o = excp_vec_i;
            end else if (mem_stallreq_i) begin
                stall_o  = 5'b01111;
                bubble_o = 5'b10000;
            end else if (ex_stallreq_i) begin
                stall_o  = 5'b00111;
                bubble_o = 5'b01000;
            end else if (id_stallreq_i) begin
                stall_o  = 5'b00011;
                bubble_o = 5'b00100;
            end else if (if_stallreq_i) begin
                stall_o  = 5'b00001;
                bubble_o = 5'b00010;
            end
        end
    end

    assign stall_any = |stall_o;

    always_comb begin
        wd_nxt = '0;
        if (stall_any) begin
            wd_nxt = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            vec_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                if (excp_i && mem_stallreq_i) begin
                    state_q <= PEND;
                    vec_q   <= excp_vec_i;
                end
            end else if (!mem_stallreq_i) begin
                state_q <= RUN;
            end
            if (stall_any && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            wd_q <= wd_nxt;
            // Set on the edge that closes the TIMEOUT-th consecutive stalled cycle.
            if ((TIMEOUT != 0) && (wd_nxt == WD_MAX)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign excp_pending_o = (state_q == PEND);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;
    assign timeout_o      = timeout_q;

endmodule
